// File: rtl/sha_digest_serializer.sv
// rtl/sha_digest_serializer.sv - streams a captured SHA digest out as WORD_W-bit words, MSB word first
// Optional feature macro: SER_BYTE_SWAP_EN (byte-reverse each output word)
module sha_digest_serializer #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [1:0]        sel_mux_res_sha,
    input  logic [511:0]      res_in,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(512 / WORD_W);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [511:0]       shift_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_init;
    logic               load_ok;
    logic               load_bad;
    logic               handshake;
    logic               last_word;
    logic [WORD_W-1:0]  head_word;
    logic [WORD_W-1:0]  bus_word;

    // Word count minus one for the requested mode; the illegal mode never reaches the counter
    always_comb begin
        cnt_init = '0;
        case (sel_mux_res_sha)
            2'b00:   cnt_init = CNT_W'(256 / WORD_W - 1);
            2'b01:   cnt_init = CNT_W'(384 / WORD_W - 1);
            2'b10:   cnt_init = CNT_W'(512 / WORD_W - 1);
            default: cnt_init = '0;
        endcase
    end

    assign load_ok   = load && (state == IDLE) && (sel_mux_res_sha != 2'b11);
    assign load_bad  = load && ((state == SEND) || (sel_mux_res_sha == 2'b11));
    assign last_word = (state == SEND) && (cnt_q == '0);
    assign handshake = (state == SEND) && out_ready;
    assign head_word = shift_q[511 -: WORD_W];

`ifdef SER_BYTE_SWAP_EN
    always_comb begin
        bus_word = '0;
        for (int b = 0; b < WORD_W / 8; b++) begin
            bus_word[8*b +: 8] = head_word[WORD_W-8-8*b +: 8];
        end
    end
`else
    assign bus_word = head_word;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        out_data  = '0;
        case (state)
            IDLE: begin
                if (load_ok) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = last_word;
                busy      = 1'b1;
                out_data  = bus_word;
                if (handshake && last_word) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (load_ok) begin
                shift_q <= res_in;
                cnt_q   <= cnt_init;
            end else if (handshake) begin
                shift_q <= {shift_q[511-WORD_W:0], {WORD_W{1'b0}}};
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
            done <= handshake && last_word;
            // Sticky until reset so firmware can see a misuse that happened long ago
            if (load_bad) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sha_digest_serializer.sv
// tb/tb_sha_digest_serializer.sv - directed vector bench for sha_digest_serializer (WORD_W=32)
module tb_sha_digest_serializer;

    localparam int WW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [1:0]    sel_mux_res_sha;
    logic [511:0]  res_in;
    logic [WW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;

    int n_cmp  = 0;
    int n_fail = 0;

    sha_digest_serializer #(.WORD_W(WW)) dut (
        .clk             (clk),
        .rst             (rst),
        .load            (load),
        .sel_mux_res_sha (sel_mux_res_sha),
        .res_in          (res_in),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [7:0]  base;
        logic [15:0] ready_mask;
        int          exp_n;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        int          inject_at;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [31:0] bus_view(input logic [31:0] w);
`ifdef SER_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [511:0] make_digest(input logic [7:0] base, input int nbytes);
        logic [511:0] r;
        r = '0;
        for (int b = 0; b < nbytes; b++) begin
            r[511-8*b -: 8] = base + 8'(b);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_data"},  64'(out_data),  64'd0);
        check({tag, "_last"},  64'(out_last),  64'd0);
        check({tag, "_busy"},  64'(busy),      64'd0);
    endtask

    // Called at a falling edge; returns at a falling edge one cycle after the done pulse
    task automatic run_stream(input vec_t v, input string tag);
        logic [511:0] dig;
        logic [WW-1:0] prev_d;
        logic          prev_l;
        logic          prev_stall;
        logic          finished;
        logic [31:0]   exp_w;
        int            idx;
        int            cyc;
        dig = make_digest(v.base, v.exp_n * WW / 8);
        sel_mux_res_sha = v.sel;
        res_in = dig;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        sel_mux_res_sha = ~v.sel;
        res_in = ~dig;
        check({tag, "_first_valid"}, 64'(out_valid), 64'd1);
        idx = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_d = '0;
        prev_l = 1'b0;
        finished = 1'b0;
        while (!finished && cyc < 200) begin
            out_ready = v.ready_mask[cyc % 16];
            check({tag, "_valid_held"}, 64'(out_valid), 64'd1);
            if (prev_stall) begin
                check({tag, "_stall_data"}, 64'(out_data), 64'(prev_d));
                check({tag, "_stall_last"}, 64'(out_last), 64'(prev_l));
            end
            if (idx == v.inject_at) begin
                load = 1'b1;
                sel_mux_res_sha = 2'b01;
            end
            if (out_valid && out_ready) begin
                exp_w = bus_view(dig[511-WW*idx -: WW]);
                check({tag, "_data"}, 64'(out_data), 64'(exp_w));
                check({tag, "_last"}, 64'(out_last), 64'(idx == v.exp_n - 1));
                if (idx == 0) check({tag, "_first_word"}, 64'(out_data), 64'(bus_view(v.exp_first)));
                if (idx == v.exp_n - 1) begin
                    check({tag, "_last_word"}, 64'(out_data), 64'(bus_view(v.exp_last)));
                    finished = 1'b1;
                end
                idx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
            @(negedge clk);
            load = 1'b0;
            cyc++;
        end
        if (!finished) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: %0d words seen, expected %0d", tag, idx, v.exp_n);
        end
        check({tag, "_count"}, 64'(idx), 64'(v.exp_n));
        check({tag, "_done"}, 64'(done), 64'd1);
        check_idle_outputs({tag, "_post"});
        @(negedge clk);
        check({tag, "_done_once"}, 64'(done), 64'd0);
        check({tag, "_stay_idle"}, 64'(out_valid), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{sel: 2'b00, base: 8'h00, ready_mask: 16'hFFFF, exp_n: 8,
                    exp_first: 32'h00010203, exp_last: 32'h1C1D1E1F, inject_at: -1};
        vecs[1] = '{sel: 2'b01, base: 8'h40, ready_mask: 16'hFFFF, exp_n: 12,
                    exp_first: 32'h40414243, exp_last: 32'h6C6D6E6F, inject_at: -1};
        vecs[2] = '{sel: 2'b10, base: 8'h80, ready_mask: 16'hFFFF, exp_n: 16,
                    exp_first: 32'h80818283, exp_last: 32'hBCBDBEBF, inject_at: -1};
        vecs[3] = '{sel: 2'b00, base: 8'h10, ready_mask: 16'h9999, exp_n: 8,
                    exp_first: 32'h10111213, exp_last: 32'h2C2D2E2F, inject_at: -1};

        rst = 1'b1;
        load = 1'b0;
        sel_mux_res_sha = 2'b00;
        res_in = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_done", 64'(done), 64'd0);
        check("reset_err",  64'(err),  64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_stream(vecs[i], $sformatf("vec%0d", i));
        end
        check("legal_no_err", 64'(err), 64'd0);

        // Load mid-stream on word 3 of SHA-512 is ignored but flagged
        v = vecs[2];
        v.inject_at = 2;
        run_stream(v, "midload");
        check("midload_err", 64'(err), 64'd1);

        // Load coinciding with the final handshake is still seen in SEND
        rst = 1'b1;
        @(negedge clk);
        check("err_cleared", 64'(err), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        v = vecs[0];
        v.inject_at = 7;
        run_stream(v, "lastload");
        check("lastload_err", 64'(err), 64'd1);

        // Illegal mode from IDLE sets err and captures nothing
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sel_mux_res_sha = 2'b11;
        res_in = make_digest(8'h55, 64);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("illegal_err", 64'(err), 64'd1);
        check_idle_outputs("illegal");
        @(negedge clk);
        check("illegal_still_idle", 64'(out_valid), 64'd0);
        run_stream(vecs[0], "after_illegal");
        check("after_illegal_err", 64'(err), 64'd1);

        // Async reset while word 5 of SHA-512 is presented
        sel_mux_res_sha = 2'b10;
        res_in = make_digest(8'h20, 64);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_word5", 64'(out_data), 64'(bus_view(32'h30313233)));
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        check("async_rst_err",  64'(err),  64'd0);
        check("async_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        check("rst_no_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_no_done2", 64'(done), 64'd0);
        check("rst_idle", 64'(out_valid), 64'd0);
        run_stream(vecs[0], "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
